// File: rtl/exmem_dmem_ctrl_if.sv
// Bundle of EX/MEM-side controls, the data-memory req/ack port and MEM/WB-side results.
// The controller connects through the slave modport; the pipeline/memory side uses master.
interface exmem_dmem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // EX/MEM register contents
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       alu_res;
    logic [DATA_W-1:0] rs2;

    // Data-memory port. dmem_req rises together with a latched dmem_addr/dmem_we/dmem_wdata
    // and holds all three stable until a rising edge at which dmem_ack is high; that edge
    // completes the transfer (dmem_rdata is taken at it for reads) and dmem_req drops.
    // dmem_ack seen while dmem_req is low carries no meaning and is ignored.
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;

    // MEM/WB results and pipeline control
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              stall;
    logic              misalign;
    logic              bus_err;

    modport slave (
        input  mem_read, mem_write, alu_res, rs2, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output rdata, rdata_valid, stall, misalign, bus_err
    );

    modport master (
        output mem_read, mem_write, alu_res, rs2, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  rdata, rdata_valid, stall, misalign, bus_err
    );
endinterface

// File: rtl/exmem_dmem_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: IDLE -> REQ -> DONE, with
// pipeline stall, misalignment rejection and a saturating request timeout.
module exmem_dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clock_i,
    input  logic                reset_i,
    exmem_dmem_ctrl_if.slave    bus,
    output logic [1:0]          state_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              misalign_q;
    logic              bus_err_q;

    logic acc;
    logic aligned;
    logic start;

    always_comb begin
        acc     = bus.mem_read | bus.mem_write;
        aligned = (bus.alu_res[1:0] == 2'b00);
        // Reset gates the detect stall so every output reads 0 while reset is held.
        start   = (state_q == S_IDLE) && acc && aligned && !reset_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= bus.alu_res[ADDR_W-1:0];
                        wdata_q <= bus.rs2;
                        we_q    <= bus.mem_write;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end else if (acc) begin
                        misalign_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.dmem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                        if (!we_q) begin
                            rdata_q  <= bus.dmem_rdata;
                            rvalid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        // Only reached below CNT_LAST, so the counter can never wrap.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall       = start || (state_q == S_REQ);
    assign bus.dmem_req    = req_q;
    assign bus.dmem_we     = we_q;
    assign bus.dmem_addr   = addr_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.misalign    = misalign_q;
    assign bus.bus_err     = bus_err_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_exmem_dmem_ctrl.sv
// Bench for exmem_dmem_ctrl: directed scenarios plus randomized accesses checked against a
// transaction-level expectation (stall/req lengths, pulses, load-data queue).
module tb_exmem_dmem_ctrl;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state;

    always #5 clk = ~clk;

    exmem_dmem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    exmem_dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus),
        .state_o (state)
    );

    // scoreboard
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_rdata = '0;
    bit                mis_pending = 1'b0;
    bit                spur_en     = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_ack_idle();
        bus.dmem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.dmem_rdata = $urandom;
    endtask

    // One EX/MEM instruction; ack_delay = REQ cycles without ack before the ack cycle,
    // ack_delay >= TIMEOUT means memory never answers.
    task automatic run_instr(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [DATA_W-1:0] data, input int ack_delay,
                             input logic [DATA_W-1:0] rval);
        bit acc    = rd | wr;
        bit ok     = acc && (addr[1:0] == 2'b00);
        bit is_ld  = rd && !wr;
        bit acked  = (ack_delay < TIMEOUT);
        int req_n  = acked ? ack_delay + 1 : TIMEOUT;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.alu_res   = addr;
        bus.rs2       = data;
        drive_ack_idle();
        @(negedge clk);
        check("stall_detect", 64'(bus.stall), 64'(ok));
        check("req_detect", 64'(bus.dmem_req), 64'd0);
        check("misalign", 64'(bus.misalign), 64'(mis_pending));
        check("rvalid_idle", 64'(bus.rdata_valid), 64'd0);
        check("buserr_idle", 64'(bus.bus_err), 64'd0);
        check("rdata_hold", 64'(bus.rdata), 64'(model_rdata));
        mis_pending = acc && !ok;
        if (ok) begin
            if (is_ld && acked) exp_q.push_back(rval);
            for (int k = 0; k < req_n; k++) begin
                @(posedge clk); #1;
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
                @(negedge clk);
                check("req_high", 64'(bus.dmem_req), 64'd1);
                check("stall_req", 64'(bus.stall), 64'd1);
                check("req_we", 64'(bus.dmem_we), 64'(wr));
                check("req_addr", 64'(bus.dmem_addr), 64'(addr[ADDR_W-1:0]));
                check("req_wdata", 64'(bus.dmem_wdata), 64'(data));
                if (acked && k == ack_delay) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rval;
                end
            end
            @(posedge clk); #1;
            drive_ack_idle();
            @(negedge clk);
            check("done_stall", 64'(bus.stall), 64'd0);
            check("done_req", 64'(bus.dmem_req), 64'd0);
            check("done_rvalid", 64'(bus.rdata_valid), 64'(is_ld && acked));
            check("done_buserr", 64'(bus.bus_err), 64'(!acked));
            check("done_misalign", 64'(bus.misalign), 64'd0);
            if (is_ld && acked) model_rdata = exp_q.pop_front();
            check("done_rdata", 64'(bus.rdata), 64'(model_rdata));
        end
        @(posedge clk); #1;
    endtask

    task automatic bubble();
        run_instr(1'b0, 1'b0, 32'h0, '0, 0, '0);
    endtask

    // Reset lands while the request is outstanding, then the same load is re-run cleanly.
    task automatic reset_mid_req();
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        bus.alu_res   = 32'h80;
        bus.rs2       = '0;
        bus.dmem_ack  = 1'b0;
        @(negedge clk);
        check("rst_t_stall", 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_t_req", 64'(bus.dmem_req), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req", 64'(bus.dmem_req), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_rvalid", 64'(bus.rdata_valid), 64'd0);
        check("rst_buserr", 64'(bus.bus_err), 64'd0);
        check("rst_misalign", 64'(bus.misalign), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        model_rdata = '0;
        exp_q.delete();
        mis_pending = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(1'b1, 1'b0, 32'h80, '0, 0, 32'hCAFE_F00D);
    endtask

    initial begin
        logic [31:0] a;
        bit          rd;
        bit          wr;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_res    = '0;
        bus.rs2        = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", 64'(bus.dmem_req), 64'd0);
        check("reset_we", 64'(bus.dmem_we), 64'd0);
        check("reset_addr", 64'(bus.dmem_addr), 64'd0);
        check("reset_wdata", 64'(bus.dmem_wdata), 64'd0);
        check("reset_rdata", 64'(bus.rdata), 64'd0);
        check("reset_pulses", 64'({bus.rdata_valid, bus.misalign, bus.bus_err, bus.stall}), 64'd0);
        check("reset_state", 64'(state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed scenarios
        run_instr(1'b1, 1'b0, 32'h40, '0, 1, 32'hDEAD_BEEF);
        run_instr(1'b0, 1'b1, 32'h100, 32'h1234_5678, 0, '0);
        run_instr(1'b1, 1'b0, 32'h43, '0, 0, 32'h1111_1111);
        bubble();
        run_instr(1'b1, 1'b0, 32'h200, '0, TIMEOUT, 32'h2222_2222);
        bubble();
        run_instr(1'b1, 1'b0, 32'h204, '0, TIMEOUT - 1, 32'h3333_3333);
        run_instr(1'b1, 1'b1, 32'h208, 32'hA5A5_0F0F, 2, 32'h4444_4444);
        reset_mid_req();
        spur_en = 1'b1;
        bubble();
        run_instr(1'b1, 1'b0, 32'h300, '0, 0, 32'h5555_AAAA);
        run_instr(1'b0, 1'b1, 32'h304, 32'h0BAD_F00D, 1, '0);
        bubble();
        bubble();

        // randomized accesses
        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr(rd, wr, a, $urandom, $urandom_range(0, TIMEOUT + 1), $urandom);
            if ($urandom_range(0, 2) == 0) bubble();
        end
        bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
